// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop; one CLK per bit.
// Outputs are registered or decoded from state, so no input reaches an output combinationally; requests while busy are dropped.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  SER_DATA,
  output logic                  PARITY_BIT,
  output logic [1:0]            MUX_SEL,
  output logic                  BUSY
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt;
  logic                  par_en_q;
  logic                  parity_q;
  logic                  accept;
  logic                  last_bit;

  assign accept   = (state == IDLE) && DATA_VALID;
  assign last_bit = (state == DATA) && (bit_cnt == LAST_CNT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (DATA_VALID) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (last_bit) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter holds at its last value on the final data cycle so it never wraps
  // when DATA_WIDTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      parity_q  <= 1'b0;
    end else if (accept) begin
      shift_reg <= P_DATA;
      bit_cnt   <= '0;
      par_en_q  <= PAR_EN;
      parity_q  <= (^P_DATA) ^ PAR_TYP;
    end else if (state == DATA) begin
      shift_reg <= shift_reg >> 1;
      if (!last_bit) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    MUX_SEL = SEL_STOP;
    BUSY    = 1'b1;
    case (state)
      IDLE:    begin MUX_SEL = SEL_STOP;   BUSY = 1'b0; end
      START:   MUX_SEL = SEL_START;
      DATA:    MUX_SEL = SEL_DATA;
      PARITY:  MUX_SEL = SEL_PARITY;
      STOP:    MUX_SEL = SEL_STOP;
      default: begin MUX_SEL = SEL_STOP;   BUSY = 1'b0; end
    endcase
  end

  assign SER_DATA   = shift_reg[0];
  assign PARITY_BIT = parity_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame sequencing, parity, busy handling and reset abort.
module tb_uart_tx_ctrl;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       SER_DATA;
  logic       PARITY_BIT;
  logic [1:0] MUX_SEL;
  logic       BUSY;

  int tests;
  int fails;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .SER_DATA   (SER_DATA),
    .PARITY_BIT (PARITY_BIT),
    .MUX_SEL    (MUX_SEL),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] sel, input logic busy);
    chk({tag, " sel"}, {6'd0, MUX_SEL}, {6'd0, sel});
    chk({tag, " busy"}, {7'd0, BUSY}, {7'd0, busy});
  endtask

  // Sends one frame and checks every cycle; mid-frame the config inputs are
  // replaced by mid_d/mid_pen/flipped type and DATA_VALID by mid_dv.
  task automatic send(input string tag, input logic [7:0] d, input logic pen,
                      input logic typ, input logic exp_par,
                      input logic [7:0] mid_d, input logic mid_pen, input logic mid_dv);
    P_DATA = d; PAR_EN = pen; PAR_TYP = typ; DATA_VALID = 1'b1;
    tick();
    chk_state({tag, " start"}, 2'b00, 1'b1);
    chk({tag, " parity_at_start"}, {7'd0, PARITY_BIT}, {7'd0, exp_par});
    P_DATA = mid_d; PAR_EN = mid_pen; PAR_TYP = ~typ; DATA_VALID = mid_dv;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_state($sformatf("%s data%0d", tag, i), 2'b10, 1'b1);
      chk($sformatf("%s ser%0d", tag, i), {7'd0, SER_DATA}, {7'd0, d[i]});
    end
    if (pen) begin
      tick();
      chk_state({tag, " parity"}, 2'b11, 1'b1);
      chk({tag, " parity_bit"}, {7'd0, PARITY_BIT}, {7'd0, exp_par});
    end
    tick();
    chk_state({tag, " stop"}, 2'b01, 1'b1);
    DATA_VALID = 1'b0;
    tick();
    chk_state({tag, " idle"}, 2'b01, 1'b0);
    chk({tag, " parity_held"}, {7'd0, PARITY_BIT}, {7'd0, exp_par});
  endtask

  initial begin
    logic [7:0] acc;
    int         ph;
    tests = 0;
    fails = 0;
    RST = 1'b1;
    P_DATA = 8'($urandom);
    DATA_VALID = 1'($urandom);
    PAR_EN = 1'($urandom);
    PAR_TYP = 1'($urandom);

    // 1: reset with random inputs, then idle
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_state("reset", 2'b01, 1'b0);
      chk("reset ser", {7'd0, SER_DATA}, 8'd0);
      chk("reset par", {7'd0, PARITY_BIT}, 8'd0);
      P_DATA = 8'($urandom);
      DATA_VALID = 1'($urandom);
      PAR_EN = 1'($urandom);
      PAR_TYP = 1'($urandom);
    end
    RST = 1'b0;
    DATA_VALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_state("idle_hold", 2'b01, 1'b0);
    end

    // 2: 0xA5 even parity -> bits 1,0,1,0,0,1,0,1, parity 0
    send("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // 3: 0x01 odd -> 0, even -> 1
    send("01_odd", 8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    send("01_even", 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);

    // 4: 0xFF no parity, config and request toggled mid-frame
    send("ff_nopar", 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // 5: DATA_VALID held high, P_DATA = 0x10 + cycle; 11-cycle frame period
    acc = 8'h00;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    DATA_VALID = 1'b1;
    for (int c = 0; c < 33; c++) begin
      P_DATA = 8'(8'h10 + c);
      tick();
      ph = c % 11;
      if (ph == 0) begin
        acc = 8'(8'h10 + c);
        chk_state($sformatf("stream c%0d start", c), 2'b00, 1'b1);
        chk($sformatf("stream c%0d parity", c), {7'd0, PARITY_BIT}, {7'd0, ^acc});
      end else if (ph <= 8) begin
        chk_state($sformatf("stream c%0d data", c), 2'b10, 1'b1);
        chk($sformatf("stream c%0d ser", c), {7'd0, SER_DATA}, {7'd0, acc[ph-1]});
      end else if (ph == 9) begin
        chk_state($sformatf("stream c%0d stop", c), 2'b01, 1'b1);
      end else begin
        chk_state($sformatf("stream c%0d idle", c), 2'b01, 1'b0);
      end
    end
    DATA_VALID = 1'b0;
    tick();
    chk_state("stream end idle", 2'b01, 1'b0);
    tick();

    // 6: reset during 4th data cycle of 0x3C, then 0xC3 completes
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    tick();
    chk_state("abort start", 2'b00, 1'b1);
    DATA_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_state($sformatf("abort data%0d", i), 2'b10, 1'b1);
      chk($sformatf("abort ser%0d", i), {7'd0, SER_DATA}, {7'd0, 1'(8'h3C >> i)});
    end
    RST = 1'b1;
    DATA_VALID = 1'b1;
    tick();
    chk_state("abort reset", 2'b01, 1'b0);
    chk("abort ser", {7'd0, SER_DATA}, 8'd0);
    chk("abort par", {7'd0, PARITY_BIT}, 8'd0);
    RST = 1'b0;
    DATA_VALID = 1'b0;
    tick();
    chk_state("abort idle", 2'b01, 1'b0);
    send("c3_after_abort", 8'hC3, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
